reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Parametrised register file plus latency scoreboard for the decode stage. It holds the integer and floating-point register classes behind one tagged address space and serves NRD read ports with write-back forwarding. It tracks per-register in-flight latency and raises a single issue-ready handshake, so decode stalls on RAW and WAW hazards instead of relying on fixed hazard rules. It sits between instruction decode and the execute pipeline register, and takes writes from the write-back stage.

## Interface

Parameters:
- XLEN, 32: data width.
- NREG, 32: registers per class; AW = $clog2(NREG).
- NCLS, 2: register classes (0 = gpr, 1 = fpr); the tag width is TW = AW + $clog2(NCLS).
- NRD, 2: read ports.
- LW, 5: latency field width; the maximum latency is 2^LW−1.
- ZERO_REG, 1: when 1, class 0 register 0 reads 0, ignores writes and is never busy.

Ports:
- clk: input, 1. Clock.
- rst: input, 1. Asynchronous, active-high reset.
- rd_tag: input, NRD*TW. Source tags, packed as {class, index}; port i is at [i*TW +: TW].
- rd_data: output, NRD*XLEN. Registered read data per port.
- iss_valid: input, 1. Decode presents an instruction.
- iss_ready: output, 1. Combinational; high when no hazard.
- iss_we: input, 1. The instruction writes a destination.
- iss_dst: input, TW. Destination tag.
- iss_lat: input, LW. Cycles from issue until the result is forwardable.
- rd_use: input, NRD. Per-port flag: the source is actually consumed.
- wb_en: input, 1. Write-back strobe.
- wb_tag: input, TW. Write-back destination tag.
- wb_data: input, XLEN. Write-back data.
- busy_any: output, 1. High when any register is pending.

## Operation

- Storage is NCLS×NREG×XLEN. Per register it also holds a countdown cnt[LW-1:0] and a pending bit pend.
- A fire occurs when iss_valid and iss_ready are both high.
- On a fire with iss_we, and iss_dst not the zero register:
  - pend[dst] is set to 1.
  - cnt[dst] is set to iss_lat.
  - If iss_lat is 0, only pend is set.
- Every cycle, each nonzero cnt decrements by 1. It never wraps below 0.
- On wb_en: regs[wb_tag] is written with wb_data, and pend and cnt are cleared, except for the zero register.
- If a fire and wb_en target the same tag in the same cycle, the issue wins: pend is set and cnt is loaded. The data write still happens.
- Hazard for a port with rd_use[i] high: hazard if cnt[rd_tag[i]] != 0.
- WAW hazard: iss_we high and pend[iss_dst] is 1.
- iss_ready is low when any RAW hazard or the WAW hazard exists; otherwise it is high.
- iss_ready is independent of iss_valid, so there is no combinational loop.
- Read data path:
  - Each cycle, rd_data[i] is loaded with regs[rd_tag[i]], or the bypass value (see Configuration).
  - The zero register always reads 0.
- busy_any is the OR of all pend bits.

## Timing

- Reset, asynchronous and immediate:
  - All regs are 0. The exceptions are class 0 regs 29 = 32'h000F4240 and 28 = 32'h00000030, which are the stack and heap preset.
  - All cnt and pend are 0.
  - rd_data is 0, busy_any is 0, and iss_ready is 1.
- Read latency is 1 cycle: rd_tag in cycle N produces rd_data in cycle N+1.
- Register write latency is 1 cycle. A write in cycle N is visible through storage in cycle N+1.
- Issue with latency L in cycle N, consumer of the same tag:
  - iss_ready is low in cycles N+1 through N+L.
  - iss_ready is high at N+L+1, or earlier if wb_en clears the entry.
- WAW stall lasts until the wb_en cycle (bypass on) or the cycle after it (bypass off).
- If rst asserts mid-operation, all pending state is dropped. Any in-flight write-back arriving after reset deasserts is written normally, and is not scoreboarded.

## Configuration

- REG_SCOREBOARD_BYPASS_EN defined:
  - When wb_en and wb_tag == rd_tag[i] in the same cycle, rd_data[i] captures wb_data.
  - A RAW or WAW hazard on a tag whose wb_en is high in that cycle is treated as cleared, so iss_ready can be high that cycle.
- Macro undefined:
  - No bypass; rd_data captures the old storage value.
  - Hazards clear only in the cycle after wb_en, via the cleared cnt and pend.

## Test plan

- Reset, then read class 0 reg 29 and reg 0 → rd_data is 32'h000F4240 and 0; busy_any is 0; iss_ready is 1.
- Issue writing gpr5 with iss_lat=4 in cycle 0, then a consumer of gpr5 with rd_use → iss_ready is low for cycles 1–4 and high at cycle 5.
- Issue writing fpr3 (lat 6), then an issue writing fpr3 again → WAW stall. With wb_en on fpr3 = 32'h3F800000, the stall ends that cycle (bypass on) or the next cycle (off). rd_data on fpr3 returns 32'h3F800000.
- Same-cycle fire on gpr7 (lat 3) and wb_en on gpr7 → pend[gpr7] stays 1; cnt is 3; storage holds the wb_data value.
- Write 32'hDEADBEEF to class 0 reg 0 → reads 0, never busy, and no stall on an issue targeting it.
- Issue gpr9 with lat 31, then assert rst at cycle 10 → busy_any is 0 and iss_ready is 1 immediately; gpr9 reads 0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Tagged GPR/FPR register file with registered read ports and a per-register latency scoreboard.
// Optional write-back bypass on reads and hazard clearing: define REG_SCOREBOARD_BYPASS_EN.
module reg_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NCLS     = 2,
    parameter int NRD      = 2,
    parameter int LW       = 5,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG),
    localparam int TW      = AW + $clog2(NCLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*TW-1:0]   rd_tag,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic                iss_we,
    input  logic [TW-1:0]       iss_dst,
    input  logic [LW-1:0]       iss_lat,
    input  logic [NRD-1:0]      rd_use,
    input  logic                wb_en,
    input  logic [TW-1:0]       wb_tag,
    input  logic [XLEN-1:0]     wb_data,
    output logic                busy_any
);

    // Tags are {class, index}, so class 0 occupies entries 0..NREG-1.
    localparam int NENT = 2 ** TW;
`ifdef REG_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [XLEN-1:0]            regs [NENT];
    logic [LW-1:0]              cnt  [NENT];
    logic [NENT-1:0]            pend;
    logic [NRD-1:0][TW-1:0]     src;
    logic [NRD-1:0][XLEN-1:0]   rd_nxt;
    logic [NRD-1:0][XLEN-1:0]   rd_q;
    logic [NRD-1:0]             raw;
    logic                       waw;
    logic                       fire;
    logic                       iss_set;
    logic                       wb_set;

    function automatic logic is_zero(input logic [TW-1:0] t);
        return (ZERO_REG != 0) && (t == '0);
    endfunction

    // Stack and heap pointer presets live in gpr29 / gpr28.
    function automatic logic [XLEN-1:0] preset(input int e);
        if (NREG > 29 && e == 29) return XLEN'(32'h000F4240);
        if (NREG > 28 && e == 28) return XLEN'(32'h00000030);
        return '0;
    endfunction

    assign src      = rd_tag;
    assign rd_data  = rd_q;
    assign busy_any = |pend;
    assign fire     = iss_valid && iss_ready;
    assign iss_set  = fire && iss_we && !is_zero(iss_dst);
    assign wb_set   = wb_en && !is_zero(wb_tag);

    // Hazards; with bypass a same-cycle write-back to the tag counts as resolved.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NRD; i++) begin
            raw[i] = rd_use[i] && (cnt[src[i]] != '0)
                     && !(BYP && wb_en && (wb_tag == src[i]));
        end
        waw = iss_we && pend[iss_dst] && !(BYP && wb_en && (wb_tag == iss_dst));
        iss_ready = !(|raw) && !waw;
    end

    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_nxt[i] = regs[src[i]];
            if (BYP && wb_en && (wb_tag == src[i])) rd_nxt[i] = wb_data;
            if (is_zero(src[i])) rd_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NENT; e++) regs[e] <= preset(e);
        end else if (wb_set) begin
            regs[wb_tag] <= wb_data;
        end
    end

    // Issue beats write-back on the same tag: the new producer owns the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            for (int e = 0; e < NENT; e++) cnt[e] <= '0;
        end else begin
            for (int e = 0; e < NENT; e++) begin
                if (iss_set && (iss_dst == TW'(e))) begin
                    pend[e] <= 1'b1;
                    cnt[e]  <= iss_lat;
                end else if (wb_set && (wb_tag == TW'(e))) begin
                    pend[e] <= 1'b0;
                    cnt[e]  <= '0;
                end else if (cnt[e] != '0) begin
                    cnt[e]  <= cnt[e] - LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector bench for reg_scoreboard; expectations follow REG_SCOREBOARD_BYPASS_EN if defined.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rd_tag;
    logic [63:0] rd_data;
    logic        iss_valid, iss_ready, iss_we;
    logic [5:0]  iss_dst;
    logic [4:0]  iss_lat;
    logic [1:0]  rd_use;
    logic        wb_en;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data;
    logic        busy_any;

    int n_cmp = 0;
    int n_err = 0;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .rd_tag(rd_tag), .rd_data(rd_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_we(iss_we),
        .iss_dst(iss_dst), .iss_lat(iss_lat), .rd_use(rd_use),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  t0, t1;
        logic [1:0]  ru;
        logic        v, we;
        logic [5:0]  dst;
        logic [4:0]  lat;
        logic        wb;
        logic [5:0]  wt;
        logic [31:0] wd;
        logic        rdy, busy;
        logic [31:0] r0, r1;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic [5:0] t0, t1, input logic [1:0] ru,
                                input logic v, we, input logic [5:0] dst, input logic [4:0] lat,
                                input logic wb, input logic [5:0] wt, input logic [31:0] wd,
                                input logic rdy, busy, input logic [31:0] r0, r1);
        vec_t x;
        x.t0 = t0; x.t1 = t1; x.ru = ru; x.v = v; x.we = we; x.dst = dst; x.lat = lat;
        x.wb = wb; x.wt = wt; x.wd = wd; x.rdy = rdy; x.busy = busy; x.r0 = r0; x.r1 = r1;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rd_tag = {x.t1, x.t0}; rd_use = x.ru; iss_valid = x.v; iss_we = x.we;
        iss_dst = x.dst; iss_lat = x.lat; wb_en = x.wb; wb_tag = x.wt; wb_data = x.wd;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        // tags: gpr n = n, fpr n = 32 + n
        vecs[0]  = mk(29, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h000F4240, 0);
        vecs[1]  = mk(28, 29, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h30, 32'h000F4240);
        vecs[2]  = mk(5, 0, 0, 1, 1, 5, 4, 0, 0, 0, 1, 1, 0, 0);
        vecs[3]  = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[4]  = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[7]  = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[8]  = mk(5, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 1, 0, BYP ? 32'h55 : 0, 0);
        vecs[9]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55, 0);
        vecs[10] = mk(0, 0, 0, 1, 1, 35, 6, 0, 0, 0, 1, 1, 0, 0);
        vecs[11] = mk(35, 0, 0, 1, 1, 35, 2, 0, 0, 0, 0, 1, 0, 0);
        vecs[12] = mk(35, 0, 0, 1, 1, 35, 2, 0, 0, 0, 0, 1, 0, 0);
        vecs[13] = mk(35, 0, 0, 1, 1, 35, 2, 1, 35, 32'h3F800000, BYP, BYP,
                      BYP ? 32'h3F800000 : 0, 0);
        vecs[14] = mk(35, 0, 0, 1, 1, 35, 2, 0, 0, 0, !BYP, 1, 32'h3F800000, 0);
        vecs[15] = mk(35, 0, 0, 0, 0, 0, 0, 1, 35, 32'h3F800000, 1, 0, 32'h3F800000, 0);
        vecs[16] = mk(0, 0, 1, 1, 1, 0, 5, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 1, 1, 1, 0, 5, 0, 0, 0, 1, 0, 0, 0);
        vecs[18] = mk(7, 0, 0, 1, 1, 7, 3, 1, 7, 32'h77, 1, 1, BYP ? 32'h77 : 0, 0);
        vecs[19] = mk(7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0);
        vecs[20] = mk(0, 7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h77);
        vecs[21] = mk(7, 7, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 32'h77);
        vecs[22] = mk(7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h78, 1, 0, 0, 0);
        vecs[24] = mk(7, 0, 0, 1, 1, 9, 5, 0, 0, 0, 1, 1, 32'h78, 0);
        vecs[25] = mk(9, 0, 1, 1, 0, 0, 0, 1, 9, 32'h99, BYP, 0, BYP ? 32'h99 : 0, 0);
        vecs[26] = mk(9, 0, 0, 0, 1, 10, 3, 0, 0, 0, 1, 0, 32'h99, 0);
        vecs[27] = mk(10, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 1, 1, 11, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[29] = mk(11, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[30] = mk(0, 0, 0, 1, 1, 11, 3, 0, 0, 0, 0, 1, 0, 0);
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hB, 1, 0, 0, 0);

        rst = 1'b1;
        idle();
        #1;
        chk("reset iss_ready", 32'(iss_ready), 1);
        chk("reset busy_any", 32'(busy_any), 0);
        chk("reset rd_data0", rd_data[31:0], 0);
        chk("reset rd_data1", rd_data[63:32], 0);
        #11 rst = 1'b0;

        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            chk($sformatf("v%0d iss_ready", k), 32'(iss_ready), 32'(vecs[k].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy_any", k), 32'(busy_any), 32'(vecs[k].busy));
            chk($sformatf("v%0d rd_data0", k), rd_data[31:0], vecs[k].r0);
            chk($sformatf("v%0d rd_data1", k), rd_data[63:32], vecs[k].r1);
        end

        // Long-latency producer on gpr9, then reset in the middle of its countdown.
        @(negedge clk);
        drive(mk(0, 0, 0, 1, 1, 9, 31, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            drive(mk(9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            chk($sformatf("lat31 c%0d iss_ready", c), 32'(iss_ready), 0);
            chk($sformatf("lat31 c%0d busy_any", c), 32'(busy_any), 1);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst iss_ready", 32'(iss_ready), 1);
        chk("midrst busy_any", 32'(busy_any), 0);
        chk("midrst rd_data0", rd_data[31:0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        drive(mk(9, 29, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("postrst gpr9", rd_data[31:0], 0);
        chk("postrst gpr29", rd_data[63:32], 32'h000F4240);
        @(negedge clk);
        drive(mk(9, 0, 0, 0, 0, 0, 0, 1, 9, 32'hA5, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("late wb busy_any", 32'(busy_any), 0);
        @(negedge clk);
        drive(mk(9, 0, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("late wb iss_ready", 32'(iss_ready), 1);
        @(posedge clk);
        #1;
        chk("late wb gpr9", rd_data[31:0], 32'hA5);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
